// File: rtl/iir_dout_decimator.sv
// iir_dout_decimator: power-of-two accumulate-and-dump averaging of the iir_filter output stream.
// Define DEC_ROUND_EN for round-half-up with saturation; the default build truncates (floor).
module iir_dout_decimator #(
    parameter int DW   = 9,
    parameter int KMAX = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 vin,
    input  logic signed [DW-1:0] din,
    input  logic [2:0]           dec_k,
    input  logic                 rdy,
    input  logic                 ovf_clr,
    output logic                 vout,
    output logic signed [DW-1:0] dout,
    output logic                 ovf
);
    localparam int AW = DW + KMAX;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [KMAX-1:0]      cnt;
    logic [2:0]           k_reg;
    logic [2:0]           k_lim;
    logic [2:0]           k_eff;
    logic [KMAX:0]        last_cnt;
    logic                 block_end;
    logic                 new_res;
    logic signed [DW-1:0] result;

    // The factor is latched at block start so dec_k changes only take effect on the next block.
    always_comb begin
        k_lim     = (dec_k > 3'(KMAX)) ? 3'(KMAX) : dec_k;
        k_eff     = (cnt == '0) ? k_lim : k_reg;
        sum       = acc + {{KMAX{din[DW-1]}}, din};
        last_cnt  = ((KMAX+1)'(1) << k_eff) - (KMAX+1)'(1);
        block_end = ({1'b0, cnt} == last_cnt);
        new_res   = vin && block_end;
    end

`ifdef DEC_ROUND_EN
    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (DW-1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    logic signed [AW-1:0] bias;
    logic signed [AW-1:0] shifted;

    always_comb begin
        bias    = (k_eff != 3'd0) ? (AW'(1) << (k_eff - 3'd1)) : '0;
        shifted = (sum + bias) >>> k_eff;
        if (shifted > SAT_HI)
            result = SAT_HI[DW-1:0];
        else if (shifted < SAT_LO)
            result = SAT_LO[DW-1:0];
        else
            result = shifted[DW-1:0];
    end
`else
    // Mean of M in-range samples is always in range, so no saturation is needed here.
    always_comb result = DW'(sum >>> k_eff);
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            k_reg <= '0;
            dout  <= '0;
            vout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (vin) begin
                if (cnt == '0)
                    k_reg <= k_lim;
                if (block_end) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + KMAX'(1);
                end
            end

            if (new_res) begin
                dout <= result;
                vout <= 1'b1;
            end else if (rdy) begin
                vout <= 1'b0;
            end

            // A set from an overwritten pending result beats a simultaneous clear.
            if (new_res && vout && !rdy)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_dout_decimator.sv
// Self-checking bench for iir_dout_decimator: directed scenarios plus randomized traffic
// checked against a queue-based block-averaging reference model.
module tb_iir_dout_decimator;
    logic              clock;
    logic              rst;
    logic              vin;
    logic signed [8:0] din;
    logic [2:0]        dec_k;
    logic              rdy;
    logic              ovf_clr;
    logic              vout;
    logic signed [8:0] dout;
    logic              ovf;

    int n_vec;
    int n_err;

    int                q[$];
    int                mk;
    logic              e_vout;
    logic signed [8:0] e_dout;
    logic              e_ovf;

    iir_dout_decimator #(.DW(9), .KMAX(4)) dut (
        .clock   (clock),
        .rst     (rst),
        .vin     (vin),
        .din     (din),
        .dec_k   (dec_k),
        .rdy     (rdy),
        .ovf_clr (ovf_clr),
        .vout    (vout),
        .dout    (dout),
        .ovf     (ovf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Mean of a block by floor division (or round half up with clamping).
    function automatic int model_avg(input int s, input int k);
        int m;
        int r;
        m = 1 << k;
`ifdef DEC_ROUND_EN
        s = s + m / 2;
`endif
        r = s / m;
        if ((s % m) != 0 && s < 0)
            r = r - 1;
`ifdef DEC_ROUND_EN
        if (r > 255) r = 255;
        if (r < -256) r = -256;
`endif
        return r;
    endfunction

    // One clock edge; the model consumes the inputs present at that edge.
    task automatic tick();
        int   s;
        logic nr;
        logic signed [8:0] res;
        @(posedge clock);
        nr  = 1'b0;
        res = '0;
        if (rst) begin
            q.delete();
            e_vout = 1'b0;
            e_dout = '0;
            e_ovf  = 1'b0;
        end else begin
            if (vin) begin
                if (q.size() == 0)
                    mk = (dec_k > 3'd4) ? 4 : int'(dec_k);
                q.push_back(int'(din));
                if (q.size() == (1 << mk)) begin
                    s = 0;
                    foreach (q[i]) s += q[i];
                    res = 9'(model_avg(s, mk));
                    q.delete();
                    nr = 1'b1;
                end
            end
            if (nr && e_vout && !rdy)
                e_ovf = 1'b1;
            else if (ovf_clr)
                e_ovf = 1'b0;
            if (nr) begin
                e_vout = 1'b1;
                e_dout = res;
            end else if (rdy) begin
                e_vout = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; vin = 1'b0; din = '0; rdy = 1'b1; ovf_clr = 1'b0; dec_k = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b1; din = 9'sd77; rdy = 1'b0; ovf_clr = 1'b0; dec_k = '0;
        tick();
        n_vec++;
        if (vout !== 1'b0 || dout !== 9'sd0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state vout=%b dout=%0d ovf=%b required 0/0/0", vout, dout, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        int pv[4] = '{5, -7, 255, -256};
        apply_reset();
        dec_k = 3'd0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vin = 1'b1; din = 9'(pv[i]);
            tick();
            n_vec++;
            if (vout !== 1'b1 || int'(dout) != pv[i] || vout !== e_vout || dout !== e_dout) begin
                n_err++;
                $display("FAIL passthrough[%0d] vout=%b dout=%0d required 1/%0d", i, vout, dout, pv[i]);
            end
        end
        vin = 1'b0;
        tick();
        n_vec++;
        if (vout !== 1'b0) begin
            n_err++;
            $display("FAIL passthrough_drain vout=%b required 0", vout);
        end
    endtask

    task automatic test_avg4();
        int pv[4] = '{10, 11, 12, 14};
`ifdef DEC_ROUND_EN
        int want = 12;
`else
        int want = 11;
`endif
        apply_reset();
        dec_k = 3'd2; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vin = 1'b1; din = 9'(pv[i]);
            tick();
            n_vec++;
            if (vout !== (i == 3) || (i == 3 && int'(dout) != want)) begin
                n_err++;
                $display("FAIL avg4[%0d] vout=%b dout=%0d required %b/%0d", i, vout, dout, (i == 3), want);
            end
        end
        vin = 1'b0;
    endtask

    task automatic test_neg_round();
        int pv[2] = '{-3, -4};
`ifdef DEC_ROUND_EN
        int want = -3;
`else
        int want = -4;
`endif
        apply_reset();
        dec_k = 3'd1; rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vin = 1'b1; din = 9'(pv[i]);
            tick();
            n_vec++;
            if (vout !== (i == 1) || (i == 1 && int'(dout) != want)) begin
                n_err++;
                $display("FAIL neg_round[%0d] vout=%b dout=%0d required %b/%0d", i, vout, dout, (i == 1), want);
            end
        end
        vin = 1'b0;
    endtask

    task automatic test_stall_ovf();
        // columns: vin, din, rdy, ovf_clr, expected vout, dout, ovf
        int st[4][7] = '{'{1, 1, 0, 0, 1, 1, 0},
                         '{1, 2, 0, 0, 1, 2, 1},
                         '{0, 0, 0, 1, 1, 2, 0},
                         '{1, 3, 1, 0, 1, 3, 0}};
        apply_reset();
        dec_k = 3'd0;
        for (int i = 0; i < 4; i++) begin
            vin = st[i][0] != 0; din = 9'(st[i][1]); rdy = st[i][2] != 0; ovf_clr = st[i][3] != 0;
            tick();
            n_vec++;
            if (vout !== (st[i][4] != 0) || int'(dout) != st[i][5] || ovf !== (st[i][6] != 0)) begin
                n_err++;
                $display("FAIL stall_ovf[%0d] vout=%b dout=%0d ovf=%b required %0d/%0d/%0d",
                         i, vout, dout, ovf, st[i][4], st[i][5], st[i][6]);
            end
        end
        // overflow set and clear in the same cycle: set wins
        vin = 1'b1; din = 9'sd4; rdy = 1'b0; ovf_clr = 1'b0;
        tick();
        vin = 1'b1; din = 9'sd5; ovf_clr = 1'b1;
        tick();
        n_vec++;
        if (ovf !== 1'b1 || dout !== 9'sd5) begin
            n_err++;
            $display("FAIL ovf_set_wins ovf=%b dout=%0d required 1/5", ovf, dout);
        end
        vin = 1'b0; ovf_clr = 1'b0; rdy = 1'b1;
    endtask

    task automatic test_dec_k_change();
        apply_reset();
        rdy = 1'b1; dec_k = 3'd2;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) dec_k = 3'd0;
            vin = 1'b1; din = (i < 4) ? 9'sd8 : 9'(-20 - i);
            tick();
            n_vec++;
            if (vout !== (i >= 3) || (i == 3 && dout !== 9'sd8) || (i > 3 && int'(dout) != -20 - i)) begin
                n_err++;
                $display("FAIL dec_k_change[%0d] vout=%b dout=%0d required %b/%0d",
                         i, vout, dout, (i >= 3), (i == 3) ? 8 : -20 - i);
            end
        end
        vin = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        int nres;
        apply_reset();
        rdy = 1'b1; dec_k = 3'd3;
        for (int i = 0; i < 5; i++) begin
            vin = 1'b1; din = 9'sd100;
            tick();
        end
        rst = 1'b1; vin = 1'b0;
        tick();
        n_vec++;
        if (vout !== 1'b0 || dout !== 9'sd0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_block_rst vout=%b dout=%0d ovf=%b required 0/0/0", vout, dout, ovf);
        end
        rst = 1'b0;
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            vin = (i < 8); din = 9'sd4;
            tick();
            if (vout === 1'b1) begin
                nres++;
                n_vec++;
                if (dout !== 9'sd4) begin
                    n_err++;
                    $display("FAIL reset_mid_block_val dout=%0d required 4", dout);
                end
            end
        end
        n_vec++;
        if (nres != 1) begin
            n_err++;
            $display("FAIL reset_mid_block_count results=%0d required 1", nres);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            vin     = ($urandom_range(0, 3) != 0);
            din     = 9'($urandom_range(0, 511));
            rdy     = ($urandom_range(0, 1) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0)
                dec_k = 3'($urandom_range(0, 7));
            tick();
            n_vec++;
            if (vout !== e_vout || ovf !== e_ovf || (e_vout && dout !== e_dout)) begin
                n_err++;
                $display("FAIL random[%0d] vout=%b dout=%0d ovf=%b required %b/%0d/%b",
                         i, vout, dout, ovf, e_vout, e_dout, e_ovf);
            end
        end
        rst = 1'b0; vin = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mk = 0;
        e_vout = 1'b0; e_dout = '0; e_ovf = 1'b0;
        rst = 1'b1; vin = 1'b0; din = '0; dec_k = '0; rdy = 1'b1; ovf_clr = 1'b0;
        test_reset();
        test_passthrough();
        test_avg4();
        test_neg_round();
        test_stall_ovf();
        test_dec_k_change();
        test_reset_mid_block();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
